// File: rtl/bsg_cache_sbuf_fifo_pkg.sv
// Shared types for the store-buffer FIFO: the per-entry load select encoding.
// Optional combinational bypass is enabled by BSG_CACHE_SBUF_FIFO_BYPASS_EN.
package bsg_cache_sbuf_fifo_pkg;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_DATA = 2'd1,
    SEL_NEXT = 2'd2
  } sel_e;

endpackage

// File: rtl/bsg_cache_sbuf_fifo_if.sv
// Enqueue/dequeue handshake and snoop bus of the store-buffer FIFO.
// Optional combinational bypass is enabled by BSG_CACHE_SBUF_FIFO_BYPASS_EN.
interface bsg_cache_sbuf_fifo_if #(
  parameter int width_p = 64,
  parameter int els_p   = 2
);

  logic                     v_i;
  logic [width_p-1:0]       data_i;
  logic                     ready_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     yumi_i;
  logic [els_p*width_p-1:0] el_snoop_o;
  logic [els_p-1:0]         el_v_snoop_o;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, el_snoop_o, el_v_snoop_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, el_snoop_o, el_v_snoop_o
  );

endinterface

// File: rtl/bsg_cache_sbuf_fifo_chk.sv
// Protocol checker: the consumer must not take a head that is not valid.
// Optional combinational bypass is enabled by BSG_CACHE_SBUF_FIFO_BYPASS_EN.
module bsg_cache_sbuf_fifo_chk (
  input logic clk_i,
  input logic reset_i,
  input logic v_o,
  input logic yumi_i
);

  yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
  ) else $error("bsg_cache_sbuf_fifo: yumi_i asserted while v_o is 0");

endmodule

// File: rtl/bsg_cache_sbuf_fifo_el.sv
// One store-buffer entry: holds, loads the enqueue word, or takes its younger neighbour.
// Optional combinational bypass is enabled by BSG_CACHE_SBUF_FIFO_BYPASS_EN.
module bsg_cache_sbuf_fifo_el
  import bsg_cache_sbuf_fifo_pkg::*;
#(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  sel_e               sel_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] next_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_r;

  // entry register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_r <= {width_p{1'b0}};
    end else begin
      case (sel_i)
        SEL_DATA: data_r <= data_i;
        SEL_NEXT: data_r <= next_i;
        SEL_HOLD: data_r <= data_r;
        default:  data_r <= data_r;
      endcase
    end
  end

  assign data_o = data_r;

endmodule

// File: rtl/bsg_cache_sbuf_fifo.sv
// Self-managing shift-queue store buffer with per-entry snoop, head at entry 0.
// Define BSG_CACHE_SBUF_FIFO_BYPASS_EN to pass words straight through an empty queue.
module bsg_cache_sbuf_fifo
  import bsg_cache_sbuf_fifo_pkg::*;
#(
  parameter int width_p = 64,
  parameter int els_p   = 2
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bsg_cache_sbuf_fifo_if.slave bus
);

  localparam int count_w = $clog2(els_p + 1);
  localparam logic [count_w-1:0] els_c = count_w'(els_p);

  logic [count_w-1:0] count_r;
  logic [count_w-1:0] count_m1_s;
  logic [width_p-1:0] el_data_s [els_p];
  logic               empty_s;
  logic               ready_s;
  logic               v_s;
  logic [width_p-1:0] data_s;
  logic               bypass_s;
  logic               enq_s;
  logic               deq_s;

  assign empty_s    = (count_r == {count_w{1'b0}});
  assign ready_s    = (count_r < els_c);
  assign count_m1_s = count_r - count_w'(1);

`ifdef BSG_CACHE_SBUF_FIFO_BYPASS_EN
  // head selection: an empty queue exposes the incoming word directly
  always_comb begin
    if (empty_s) begin
      v_s      = bus.v_i;
      data_s   = bus.data_i;
      bypass_s = bus.v_i & bus.yumi_i;
    end else begin
      v_s      = 1'b1;
      data_s   = el_data_s[0];
      bypass_s = 1'b0;
    end
  end
`else
  // head selection: registered head entry only
  always_comb begin
    v_s      = ~empty_s;
    data_s   = el_data_s[0];
    bypass_s = 1'b0;
  end
`endif

  // a bypassed word is consumed without touching storage
  assign enq_s = bus.v_i & ready_s & ~bypass_s;
  assign deq_s = bus.yumi_i & ~empty_s;

  // occupancy counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= {count_w{1'b0}};
    end else begin
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + count_w'(1);
        2'b01:   count_r <= count_m1_s;
        default: count_r <= count_r;
      endcase
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : g_el
    localparam logic [count_w-1:0] idx_c = count_w'(i);
    sel_e               sel_s;
    logic [width_p-1:0] next_s;

    // the last entry has no younger neighbour, so it shifts onto itself
    if (i < els_p - 1) begin : g_next
      assign next_s = el_data_s[i+1];
    end else begin : g_last
      assign next_s = el_data_s[i];
    end

    // per-entry load select
    always_comb begin
      if (deq_s) begin
        if (enq_s && (idx_c == count_m1_s)) begin
          sel_s = SEL_DATA;
        end else begin
          sel_s = SEL_NEXT;
        end
      end else if (enq_s && (idx_c == count_r)) begin
        sel_s = SEL_DATA;
      end else begin
        sel_s = SEL_HOLD;
      end
    end

    bsg_cache_sbuf_fifo_el #(.width_p(width_p)) u_el (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .sel_i   (sel_s),
      .data_i  (bus.data_i),
      .next_i  (next_s),
      .data_o  (el_data_s[i])
    );

    assign bus.el_snoop_o[i*width_p +: width_p] = el_data_s[i];
    assign bus.el_v_snoop_o[i]                  = (idx_c < count_r);
  end

  assign bus.ready_o = ready_s;
  assign bus.v_o     = v_s;
  assign bus.data_o  = data_s;

  bsg_cache_sbuf_fifo_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_o     (v_s),
    .yumi_i  (bus.yumi_i)
  );

endmodule
